proc_uart_loader: RTL and testbench

- Program loader placed directly upstream of the processor's external data-memory request port.
- Receives a binary image over a UART serial line and assembles the bytes into 32-bit words.
- Issues one single-cycle write per word into the processor memory.
- Holds the processor in reset until the whole image is written. This replaces testbench-driven memory preload on the synthesized build.

---
 rtl/proc_loader_pkg.sv | 21 ++
 rtl/uart_rx.sv | 87 ++++++++
 rtl/proc_uart_loader.sv | 114 +++++++++++
 tb/tb_proc_uart_loader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_loader_pkg.sv
// rtl/proc_loader_pkg.sv - shared state encodings and memory request constants for the UART loader
package proc_loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    WORD,
    WRITE,
    DONE
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic MEMREQ_WRITE = 1'b1;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, LSB first, one-cycle byte_val per good frame
module uart_rx
  import proc_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_val,
  output logic [7:0] byte_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          byte_val_q;
  logic [7:0]    byte_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_val_q  <= 1'b0;
      byte_data_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      byte_val_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) state_q <= RX_START;
        end
        // Half-bit wait puts every later sample near the middle of its bit.
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rx_sync_q) begin
              byte_val_q  <= 1'b1;
              byte_data_q <= shift_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_val  = byte_val_q;
  assign byte_data = byte_data_q;

endmodule

// File: rtl/proc_uart_loader.sv
// rtl/proc_uart_loader.sv - loads a UART-delivered word image into processor memory, holding the processor in reset until done
module proc_uart_loader
  import proc_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        ext_dmemreq_val,
  output logic        ext_dmemreq_type,
  output logic [31:0] ext_dmemreq_addr,
  output logic [31:0] ext_dmemreq_wdata,
  output logic        proc_rst,
  output logic        load_done
);

  logic       byte_val;
  logic [7:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_val  (byte_val),
    .byte_data (byte_data)
  );

  loader_state_e state_q;
  logic [15:0]   count_q;
  logic [15:0]   idx_q;
  logic [1:0]    bsel_q;
  logic [31:0]   word_q;
  logic          val_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          proc_rst_q;
  logic          load_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LEN0;
      count_q     <= '0;
      idx_q       <= '0;
      bsel_q      <= '0;
      word_q      <= '0;
      val_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      proc_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      val_q <= 1'b0;
      case (state_q)
        LEN0: begin
          if (byte_val) begin
            count_q[7:0] <= byte_data;
            state_q      <= LEN1;
          end
        end
        LEN1: begin
          if (byte_val) begin
            count_q[15:8] <= byte_data;
            idx_q         <= '0;
            bsel_q        <= '0;
            if ({byte_data, count_q[7:0]} == 16'd0) begin
              state_q     <= DONE;
              proc_rst_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              state_q <= WORD;
            end
          end
        end
        // Little-endian bytes shift in from the top so byte 0 ends in [7:0].
        WORD: begin
          if (byte_val) begin
            word_q <= {byte_data, word_q[31:8]};
            if (bsel_q == 2'd3) begin
              val_q   <= 1'b1;
              addr_q  <= BASE_ADDR + {14'd0, idx_q, 2'b00};
              wdata_q <= {byte_data, word_q[31:8]};
              state_q <= WRITE;
            end else begin
              bsel_q <= bsel_q + 2'd1;
            end
          end
        end
        WRITE: begin
          idx_q  <= idx_q + 16'd1;
          bsel_q <= '0;
          if (idx_q + 16'd1 == count_q) begin
            state_q     <= DONE;
            proc_rst_q  <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            state_q <= WORD;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= LEN0;
      endcase
    end
  end

  assign ext_dmemreq_val   = val_q;
  assign ext_dmemreq_type  = MEMREQ_WRITE;
  assign ext_dmemreq_addr  = addr_q;
  assign ext_dmemreq_wdata = wdata_q;
  assign proc_rst          = proc_rst_q;
  assign load_done         = load_done_q;

endmodule

// File: tb/tb_proc_uart_loader.sv
// tb/tb_proc_uart_loader.sv - scoreboard bench for proc_uart_loader at two base addresses
module tb_proc_uart_loader;

  localparam int CPB = 4;
  localparam logic [31:0] BASE_B = 32'hFFFFFFFC;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  always #5 clk = ~clk;

  logic        val_a, type_a, prst_a, done_a;
  logic [31:0] addr_a, wdata_a;
  logic        val_b, type_b, prst_b, done_b;
  logic [31:0] addr_b, wdata_b;

  proc_uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst(rst), .rx(rx),
    .ext_dmemreq_val(val_a), .ext_dmemreq_type(type_a),
    .ext_dmemreq_addr(addr_a), .ext_dmemreq_wdata(wdata_a),
    .proc_rst(prst_a), .load_done(done_a)
  );

  proc_uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .rx(rx),
    .ext_dmemreq_val(val_b), .ext_dmemreq_type(type_b),
    .ext_dmemreq_addr(addr_b), .ext_dmemreq_wdata(wdata_b),
    .proc_rst(prst_b), .load_done(done_b)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_a = 0, wr_b = 0;
  int last_val_a = -1, rst_fall_a = -1, last_bv_a = -1, bv_cnt_a = 0;
  logic rst_at_val_a = 1'b0;
  logic prev_prst_a = 1'b1;

  // Write monitor: every pulse is matched against the scoreboard of its own instance.
  always @(negedge clk) begin
    cyc++;
    if (dut_a.u_rx.byte_val) begin
      bv_cnt_a++;
      last_bv_a = cyc;
    end
    if (prev_prst_a && !prst_a) rst_fall_a = cyc;
    prev_prst_a = prst_a;
    if (val_a) begin
      wr_a++;
      last_val_a = cyc;
      rst_at_val_a = prst_a;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL write_a_unexpected addr=%h data=%h", addr_a, wdata_a);
      end else begin
        ea = qa.pop_front();
        if ({type_a, addr_a, wdata_a} !== {1'b1, 32'(ea.idx * 4), ea.data}) begin
          errors++;
          $display("FAIL write_a got type=%b addr=%h data=%h want type=1 addr=%h data=%h",
                   type_a, addr_a, wdata_a, 32'(ea.idx * 4), ea.data);
        end
      end
    end
    if (val_b) begin
      wr_b++;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL write_b_unexpected addr=%h data=%h", addr_b, wdata_b);
      end else begin
        eb = qb.pop_front();
        if ({type_b, addr_b, wdata_b} !== {1'b1, BASE_B + 32'(eb.idx * 4), eb.data}) begin
          errors++;
          $display("FAIL write_b got type=%b addr=%h data=%h want type=1 addr=%h data=%h",
                   type_b, addr_b, wdata_b, BASE_B + 32'(eb.idx * 4), eb.data);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    wr_a = 0;
    wr_b = 0;
    rst_fall_a = -1;
    last_val_a = -1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_exp(input int idx, input logic [31:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    qa.push_back(e);
    qb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL %s_drained pending_a=%0d pending_b=%0d want 0", name, qa.size(), qb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({val_a, type_a, addr_a, wdata_a} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_memreq got val=%b type=%b addr=%h data=%h want 0 1 0 0",
               val_a, type_a, addr_a, wdata_a);
    end
    checks++;
    if ({prst_a, done_a, prst_b, done_b} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_status got %b want 1010", {prst_a, done_a, prst_b, done_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    do_reset();
    push_exp(0, 32'h12345678);
    push_exp(1, 32'hDEADBEEF);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    repeat (4) @(negedge clk);
    check_drained("load");
    checks++;
    if (wr_a != 2) begin
      errors++;
      $display("FAIL load_count got %0d want 2", wr_a);
    end
    checks++;
    if (last_val_a != last_bv_a + 1) begin
      errors++;
      $display("FAIL load_write_latency got %0d want %0d", last_val_a, last_bv_a + 1);
    end
    checks++;
    if (rst_fall_a != last_val_a + 1 || rst_at_val_a !== 1'b1) begin
      errors++;
      $display("FAIL load_proc_rst_fall got %0d (rst at write %b) want %0d (1)",
               rst_fall_a, rst_at_val_a, last_val_a + 1);
    end
    checks++;
    if ({prst_a, done_a, val_a} !== 3'b010) begin
      errors++;
      $display("FAIL load_final got %b want 010", {prst_a, done_a, val_a});
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_a != 0 || wr_b != 0) begin
      errors++;
      $display("FAIL zero_writes got %0d/%0d want 0", wr_a, wr_b);
    end
    checks++;
    if (rst_fall_a != last_bv_a + 1 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got fall=%0d done=%b want fall=%0d done=1",
               rst_fall_a, done_a, last_bv_a + 1);
    end
  endtask

  task automatic test_framing();
    do_reset();
    push_exp(0, 32'h44332211);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_frame(8'h99, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (4) @(negedge clk);
    check_drained("framing");
    checks++;
    if (wr_a != 1 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL framing_count got %0d done=%b want 1 done=1", wr_a, done_a);
    end
  endtask

  task automatic test_glitch();
    int bv0;
    do_reset();
    push_exp(0, 32'hA1B2C3D4);
    send_byte(8'h01);
    send_byte(8'h00);
    bv0 = bv_cnt_a;
    @(posedge clk);
    rx = 1'b0;
    @(posedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    checks++;
    if (bv_cnt_a != bv0) begin
      errors++;
      $display("FAIL glitch_byte got %0d bytes want %0d", bv_cnt_a, bv0);
    end
    send_word(32'hA1B2C3D4);
    repeat (4) @(negedge clk);
    check_drained("glitch");
    checks++;
    if (wr_a != 1) begin
      errors++;
      $display("FAIL glitch_count got %0d want 1", wr_a);
    end
  endtask

  task automatic test_abort();
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({prst_a, done_a} !== 2'b10 || wr_a != 0 || rst_fall_a != -1) begin
      errors++;
      $display("FAIL abort_state got prst=%b done=%b writes=%0d fall=%0d want 1 0 0 -1",
               prst_a, done_a, wr_a, rst_fall_a);
    end
    push_exp(0, 32'h12345678);
    push_exp(1, 32'hDEADBEEF);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    repeat (4) @(negedge clk);
    check_drained("abort");
    checks++;
    if (wr_a != 2 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_resend got %0d done=%b want 2 done=1", wr_a, done_a);
    end
  endtask

  task automatic test_wrap_and_after_done();
    do_reset();
    push_exp(0, 32'hCAFEF00D);
    push_exp(1, 32'h0BADC0DE);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'hCAFEF00D);
    send_word(32'h0BADC0DE);
    send_word(32'h55AA55AA);
    send_byte(8'h01);
    repeat (4) @(negedge clk);
    check_drained("wrap");
    checks++;
    if (wr_b != 2 || wr_a != 2) begin
      errors++;
      $display("FAIL wrap_count got %0d/%0d want 2/2", wr_a, wr_b);
    end
    checks++;
    if (addr_b !== 32'h0 || {prst_b, done_b} !== 2'b01) begin
      errors++;
      $display("FAIL wrap_final got addr=%h prst=%b done=%b want 00000000 0 1",
               addr_b, prst_b, done_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_load();
    test_len_zero();
    test_framing();
    test_glitch();
    test_abort();
    test_wrap_and_after_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
